// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART receiver and transmitter
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_e;
    localparam int TICKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS = 8;
endpackage

// File: rtl/rx_sync2.sv
// rx_sync2: two-flop synchroniser for an asynchronous input, resets to 1 (idle-high lines)
module rx_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] s_q;
    always_ff @(posedge clk) begin
        if (!reset) s_q <= 2'b11;
        else        s_q <= {s_q[0], d_i};
    end
    assign q_o = s_q[1];
endmodule

// File: rtl/uart_rx16.sv
// uart_rx16: 16x-oversampling UART receiver with a valid/ready byte output.
// Defining UART_RX_PARITY_EN adds one even-parity bit after the data bits.
module uart_rx16
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int SAMPLE_MID = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] MID_TICK  = 4'(SAMPLE_MID);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    logic                 rx_s;
    uart_state_e          state_q;
    logic [3:0]           tick_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q;
    logic                 done_q, rx_valid_q, frame_err_q, overrun_q;
    logic                 sample;

    rx_sync2 u_sync (.clk(clk), .reset(reset), .d_i(rx), .q_o(rx_s));

    // LSB arrives first, so each new bit enters at the MSB and walks down
    assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
    assign sample  = baud16 && tick_q == LAST_TICK;

`ifdef UART_RX_PARITY_EN
    logic par_q, parity_q;
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_q <= START;
                    tick_q  <= '0;
                end
                START: if (baud16) begin
                    tick_q <= (tick_q == MID_TICK) ? 4'd0 : tick_q + 4'd1;
                    if (tick_q == MID_TICK) begin
                        state_q <= rx_s ? IDLE : DATA;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (baud16) tick_q <= tick_q + 4'd1;
                    if (sample) begin
                        shift_q <= shift_d;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == LAST_BIT) state_q <= AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud16) tick_q <= tick_q + 4'd1;
                    if (sample) begin
                        par_q   <= rx_s;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud16) tick_q <= tick_q + 4'd1;
                    if (sample) begin
                        done_q      <= rx_s;
                        frame_err_q <= !rx_s;
                        state_q     <= rx_s ? IDLE : BREAK;
                    end
                end
                BREAK: if (rx_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // a completing byte always wins; an unaccepted older byte is reported as overrun
            if (done_q) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
                parity_q   <= ^{shift_q, par_q};
`endif
            end else begin
                rx_valid_q <= rx_valid_q && !rx_ready;
                overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_q   <= 1'b0;
`endif
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx16.sv
// tb_uart_rx16: randomized and directed checks of uart_rx16 against a frame-level reference model
module tb_uart_rx16;
    logic       clk = 1'b0, reset = 1'b0, rx = 1'b1, rx_ready = 1'b1, fast = 1'b0;
    logic       baud16, rx_valid, frame_err, overrun_err, parity_err, busy;
    logic [7:0] rx_data;
    logic [1:0] bcnt = '0;
    int         n_checks = 0, n_fail = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [7:0] got[$], exp_q[$];

    uart_rx16 dut (
        .clk(clk), .reset(reset), .baud16(baud16), .rx(rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    // divide-by-4 baud16 generator: 64 clk per bit; fast mode holds baud16 high
    always @(posedge clk) bcnt <= bcnt + 2'd1;
    assign baud16 = fast || bcnt == 2'd3;

    always @(negedge clk) if (reset) begin
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) n_ferr++;
        if (overrun_err) n_ovr++;
        if (parity_err) n_perr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
        int bp;
        bp = fast ? 16 : 64;
        rx = 1'b0;
        wait_clk(bp);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(bp);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clk(bp);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop_bit;
        wait_clk(bp);
    endtask

    initial begin
        int ferr0, perr0, ovr0, exp_ferr, exp_perr;
        wait_clk(5);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        reset = 1'b1;
        wait_clk(5);

        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        wait_clk(4);
        check("a5_count", got.size(), 1);
        check("a5_data", got[0], 8'hA5);
        check("a5_ferr", n_ferr, 0);
        check("a5_busy", busy, 0);

        got.delete();
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(200);
        check("glitch_busy", busy, 0);
        check("glitch_count", got.size(), 0);
        check("glitch_ferr", n_ferr, 0);

        send_frame(8'h3C, 1'b0, even_par(8'h3C));
        rx = 1'b0;
        wait_clk(500);
        check("brk_ferr", n_ferr, 1);
        check("brk_count", got.size(), 0);
        check("brk_busy", busy, 1);
        rx = 1'b1;
        wait_clk(10);
        check("brk_release", busy, 0);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, even_par(8'h11));
        wait_clk(4);
        check("ovr_valid1", rx_valid, 1);
        check("ovr_data1", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, even_par(8'h22));
        wait_clk(4);
        check("ovr_pulse", n_ovr, 1);
        check("ovr_data2", rx_data, 8'h22);
        check("ovr_valid2", rx_valid, 1);
        rx_ready = 1'b1;
        wait_clk(2);
        check("ovr_clear", rx_valid, 0);
        check("ovr_count", got.size(), 1);
        check("ovr_accepted", got[0], 8'h22);

        got.delete();
        ferr0 = n_ferr;
        rx = 1'b0;
        wait_clk(64);
        rx = 1'b1;
        wait_clk(4 * 64 + 32);
        reset = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(1);
        check("abort_busy", busy, 0);
        check("abort_valid", rx_valid, 0);
        wait_clk(600);
        check("abort_count", got.size(), 0);
        check("abort_ferr", n_ferr, ferr0);
        send_frame(8'h5A, 1'b1, even_par(8'h5A));
        wait_clk(4);
        check("after_abort_count", got.size(), 1);
        check("after_abort_data", got[0], 8'h5A);

        got.delete();
        fast = 1'b1;
        send_frame(8'hC3, 1'b1, even_par(8'hC3));
        wait_clk(4);
        fast = 1'b0;
        check("fast_count", got.size(), 1);
        check("fast_data", got[0], 8'hC3);

`ifdef UART_RX_PARITY_EN
        got.delete();
        perr0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(4);
        check("par_ok_err", n_perr, perr0);
        check("par_ok_data", got[0], 8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(4);
        check("par_bad_err", n_perr, perr0 + 1);
        check("par_bad_count", got.size(), 2);
        check("par_bad_data", got[1], 8'h07);
`endif

        got.delete();
        exp_q.delete();
        ferr0 = n_ferr;
        perr0 = n_perr;
        ovr0 = n_ovr;
        exp_ferr = 0;
        exp_perr = 0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d;
            logic bad, flip;
            d = 8'($urandom);
            bad = $urandom_range(0, 7) == 0;
            flip = $urandom_range(0, 4) == 0;
            send_frame(d, !bad, even_par(d) ^ flip);
            if (bad) begin
                exp_ferr++;
                rx = 1'b0;
                wait_clk($urandom_range(0, 150));
                rx = 1'b1;
                wait_clk(3);
            end else begin
                exp_q.push_back(d);
`ifdef UART_RX_PARITY_EN
                if (flip) exp_perr++;
`endif
            end
            wait_clk($urandom_range(0, 100));
        end
        wait_clk(10);
        check("rand_count", got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) check($sformatf("rand_data%0d", k), got[k], exp_q[k]);
        check("rand_ferr", n_ferr - ferr0, exp_ferr);
        check("rand_perr", n_perr - perr0, exp_perr);
        check("rand_ovr", n_ovr - ovr0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
